ece571f23_g5_aes_round_seq: RTL and testbench
=============================================

ECE571F23_G5_AES_ROUND_SEQ -- requirements
Module: ece571f23_g5_aes_round_seq

Interface
REQ-001 Parameter NUM_ROUNDS, default 10, SHALL give the cipher round count; legal values are 10, 12 and 14.
REQ-002 clk  input  1  rising-edge clock; all state SHALL change only on this edge.
REQ-003 rst_n  input  1  reset, synchronous and active-low.
REQ-004 in_valid  input  1  plaintext block offered.
REQ-005 in_ready  output  1  sequencer accepts block this cycle.
REQ-006 in_block  input  128  plaintext, byte 0 in [127:120].
REQ-007 rk_in  input  128  round key for index rnd_idx, supplied combinationally by the key schedule in the same cycle.
REQ-008 rnd_idx  output  4  round index requested from the key schedule.
REQ-009 rnd_state  output  128  current state register, fed to the external round datapath (SubBytes, ShiftRows, MixColumns, AddRoundKey).
REQ-010 rnd_last  output  1  high in the final round; the datapath SHALL bypass MixColumns when it is high.
REQ-011 rnd_result  input  128  combinational round-datapath output for rnd_state, rnd_idx and rk_in.
REQ-012 out_valid  output  1  ciphertext available.
REQ-013 out_ready  input  1  consumer takes ciphertext.
REQ-014 out_block  output  128  ciphertext; SHALL equal the state register.
REQ-015 busy  output  1  high in every state except IDLE.

Function
REQ-016 The FSM SHALL have exactly three states: IDLE, ROUND and DONE.
REQ-017 IDLE:
- in_ready=1 and rnd_idx=0.
- On in_valid: state <= in_block ^ rk_in (initial AddRoundKey), rnd_idx <= 1, go to ROUND.
REQ-018 ROUND, each cycle:
- state <= rnd_result.
- If rnd_idx==NUM_ROUNDS, go to DONE; otherwise rnd_idx <= rnd_idx+1.
REQ-019 rnd_last SHALL be 1 exactly when the FSM is in ROUND and rnd_idx==NUM_ROUNDS; it SHALL be 0 otherwise.
REQ-020 DONE:
- out_valid=1.
- out_block and rnd_idx SHALL be held stable until out_ready.
- On out_ready: go to IDLE, rnd_idx <= 0.
REQ-021 Latency: a block accepted at edge T SHALL give out_valid=1 from cycle T+NUM_ROUNDS+1, which is 11 cycles for NUM_ROUNDS=10.
REQ-022 in_ready SHALL be 0 in ROUND, and in DONE except as allowed by REQ-028; in_valid SHALL be ignored while in_ready=0.
REQ-023 out_valid SHALL be 0 outside DONE.
REQ-024 rnd_idx SHALL never exceed NUM_ROUNDS and SHALL never wrap.
REQ-025 rnd_result SHALL be ignored outside ROUND.

Reset
REQ-026 When rst_n=0 at a clock edge, the following SHALL hold after that edge, including when reset occurs mid-ROUND or in DONE:
- FSM in IDLE.
- state register = 0 and rnd_idx = 0.
- out_valid = 0, busy = 0, rnd_last = 0.
- in_ready = 1 after reset releases.
REQ-027 A block in flight when reset is applied SHALL be discarded, and no out_valid SHALL be produced for it.

Configuration
REQ-028 Macro G5_AES_SEQ_BACK2BACK_EN, when defined:
- In DONE, in_ready SHALL equal out_ready.
- When out_ready && in_valid: the ciphertext is handed off, state <= in_block ^ rk_in, rnd_idx <= 1, and the FSM goes directly to ROUND.
- For this, rk_in SHALL be key 0 in DONE, so rnd_idx SHALL read 0 in DONE in this build.
REQ-029 When the macro is undefined, in_ready SHALL be 1 only in IDLE, so blocks are spaced at least NUM_ROUNDS+2 cycles apart.

Verification
REQ-030 The bench SHALL cover these directed scenarios:
- FIPS-197 C.1 vector, plaintext 00112233445566778899aabbccddeeff with key 000102030405060708090a0b0c0d0e0f and a reference round model -> out_block=69c4e0d86a7b0430d8cdb78070b4c55a, out_valid rising 11 cycles after acceptance.
- Same vector with out_ready held 0 for 5 cycles -> out_valid and out_block stable for 5 cycles, then one transfer and return to IDLE.
- Reset asserted at round 5 -> all outputs at reset values on the next cycle, no out_valid; a following vector completes correctly.
- in_valid toggled throughout ROUND -> in_ready=0 and no state disturbance.
- Two vectors with in_valid held high and out_ready=1: with the macro, outputs 11 cycles apart; without it, 12 cycles apart.
- rnd_idx sequence 0,1..10 and rnd_last high only in the rnd_idx=10 cycle -> checked every cycle for NUM_ROUNDS=10, and rnd_idx reaching 14 for NUM_ROUNDS=14.

Source files
------------

// File: rtl/ece571f23_g5_aes_round_seq.sv
// AES round sequencer: walks a block through NUM_ROUNDS iterations of an external round datapath.
// Latency: block accepted at edge T shows out_valid from cycle T+NUM_ROUNDS+1 (11 cycles for AES-128).
// Backpressure: out_valid/out_block held in DONE until out_ready; in_ready low while a block is in flight.
// Optional macro G5_AES_SEQ_BACK2BACK_EN: accept the next block in the same cycle the ciphertext leaves.
module ece571f23_g5_aes_round_seq #(
   parameter int NUM_ROUNDS = 10   // 10, 12 or 14
) (
   input  logic         clk,
   input  logic         rst_n,
   input  logic         in_valid,
   output logic         in_ready,
   input  logic [127:0] in_block,
   input  logic [127:0] rk_in,
   output logic [3:0]   rnd_idx,
   output logic [127:0] rnd_state,
   output logic         rnd_last,
   input  logic [127:0] rnd_result,
   output logic         out_valid,
   input  logic         out_ready,
   output logic [127:0] out_block,
   output logic         busy
);

   localparam logic [3:0] LAST_IDX = 4'(NUM_ROUNDS);

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      ROUND = 2'd1,
      DONE  = 2'd2
   } fsm_t;

   fsm_t         fsm;
   logic [127:0] state_q;
   logic         idle_q;   // registered copy of (fsm == IDLE) used as in_ready

   assign rnd_state = state_q;
   assign out_block = state_q;

`ifdef G5_AES_SEQ_BACK2BACK_EN
   // In DONE a new block can enter exactly when the finished one is taken.
   assign in_ready = idle_q | ((fsm == DONE) & out_ready);
`else
   assign in_ready = idle_q;
`endif

   // Sequencer FSM: initial AddRoundKey on accept, one datapath round per cycle, hold result until taken.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         fsm       <= IDLE;
         state_q   <= '0;
         rnd_idx   <= '0;
         rnd_last  <= 1'b0;
         out_valid <= 1'b0;
         busy      <= 1'b0;
         idle_q    <= 1'b1;
      end else begin
         case (fsm)
            IDLE: begin
               if (in_valid) begin
                  state_q  <= in_block ^ rk_in;
                  rnd_idx  <= 4'd1;
                  rnd_last <= (LAST_IDX == 4'd1);
                  fsm      <= ROUND;
                  busy     <= 1'b1;
                  idle_q   <= 1'b0;
               end
            end
            ROUND: begin
               state_q <= rnd_result;
               if (rnd_idx == LAST_IDX) begin
                  fsm       <= DONE;
                  rnd_last  <= 1'b0;
                  out_valid <= 1'b1;
`ifdef G5_AES_SEQ_BACK2BACK_EN
                  // Key schedule must present key 0 in DONE for a back-to-back accept.
                  rnd_idx   <= '0;
`endif
               end else begin
                  rnd_idx  <= rnd_idx + 4'd1;
                  rnd_last <= ((rnd_idx + 4'd1) == LAST_IDX);
               end
            end
            DONE: begin
               if (out_ready) begin
                  out_valid <= 1'b0;
`ifdef G5_AES_SEQ_BACK2BACK_EN
                  if (in_valid) begin
                     state_q  <= in_block ^ rk_in;
                     rnd_idx  <= 4'd1;
                     rnd_last <= (LAST_IDX == 4'd1);
                     fsm      <= ROUND;
                  end else begin
                     fsm     <= IDLE;
                     rnd_idx <= '0;
                     busy    <= 1'b0;
                     idle_q  <= 1'b1;
                  end
`else
                  fsm     <= IDLE;
                  rnd_idx <= '0;
                  busy    <= 1'b0;
                  idle_q  <= 1'b1;
`endif
               end
            end
            default: begin
               fsm       <= IDLE;
               rnd_idx   <= '0;
               rnd_last  <= 1'b0;
               out_valid <= 1'b0;
               busy      <= 1'b0;
               idle_q    <= 1'b1;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_ece571f23_g5_aes_round_seq.sv
// Bench for the AES round sequencer: AES-128 instance with a behavioural round datapath and key
// schedule, plus a 14-round instance driven by a simple toy round function.
module tb_ece571f23_g5_aes_round_seq;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic         rst_n, in_valid, in_ready, rnd_last, out_valid, out_ready, busy;
   logic [127:0] in_block, rk_in, rnd_state, rnd_result, out_block;
   logic [3:0]   rnd_idx;

   logic         in_valid_b, in_ready_b, rnd_last_b, out_valid_b, out_ready_b, busy_b;
   logic [127:0] in_block_b, rk_in_b, rnd_state_b, rnd_result_b, out_block_b;
   logic [3:0]   rnd_idx_b;

   int total = 0;
   int bad   = 0;

`ifdef G5_AES_SEQ_BACK2BACK_EN
   localparam int DONE_IDX = 0;
   localparam int EXP_GAP  = 11;
`else
   localparam int DONE_IDX = 10;
   localparam int EXP_GAP  = 12;
`endif

   logic [7:0]   sbox   [0:255];
   logic [127:0] rk_tab [0:15];

   ece571f23_g5_aes_round_seq #(.NUM_ROUNDS(10)) dut (
      .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready), .in_block(in_block),
      .rk_in(rk_in), .rnd_idx(rnd_idx), .rnd_state(rnd_state), .rnd_last(rnd_last),
      .rnd_result(rnd_result), .out_valid(out_valid), .out_ready(out_ready),
      .out_block(out_block), .busy(busy));

   ece571f23_g5_aes_round_seq #(.NUM_ROUNDS(14)) dut14 (
      .clk(clk), .rst_n(rst_n), .in_valid(in_valid_b), .in_ready(in_ready_b), .in_block(in_block_b),
      .rk_in(rk_in_b), .rnd_idx(rnd_idx_b), .rnd_state(rnd_state_b), .rnd_last(rnd_last_b),
      .rnd_result(rnd_result_b), .out_valid(out_valid_b), .out_ready(out_ready_b),
      .out_block(out_block_b), .busy(busy_b));

   // ---------------- AES arithmetic ----------------
   function automatic logic [7:0] xt(input logic [7:0] a);
      return {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
   endfunction

   function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
      logic [7:0] p = 8'h00;
      logic [7:0] x = a;
      for (int i = 0; i < 8; i++) begin
         if (b[i]) p = p ^ x;
         x = xt(x);
      end
      return p;
   endfunction

   function automatic logic [7:0] rotl8(input logic [7:0] v, input int n);
      return (v << n) | (v >> (8 - n));
   endfunction

   function automatic logic [127:0] aes_round(input logic [127:0] s, input logic [127:0] k,
                                              input logic last);
      logic [7:0]   a [16];
      logic [7:0]   t [16];
      logic [127:0] r;
      for (int i = 0; i < 16; i++) a[i] = s[127-8*i -: 8];
      for (int c = 0; c < 4; c++)
         for (int w = 0; w < 4; w++)
            t[w+4*c] = sbox[a[w+4*((c+w)%4)]];
      for (int c = 0; c < 4; c++) begin
         if (last) begin
            for (int w = 0; w < 4; w++) a[w+4*c] = t[w+4*c];
         end else begin
            a[4*c+0] = gmul(t[4*c], 2) ^ gmul(t[4*c+1], 3) ^ t[4*c+2] ^ t[4*c+3];
            a[4*c+1] = t[4*c] ^ gmul(t[4*c+1], 2) ^ gmul(t[4*c+2], 3) ^ t[4*c+3];
            a[4*c+2] = t[4*c] ^ t[4*c+1] ^ gmul(t[4*c+2], 2) ^ gmul(t[4*c+3], 3);
            a[4*c+3] = gmul(t[4*c], 3) ^ t[4*c+1] ^ t[4*c+2] ^ gmul(t[4*c+3], 2);
         end
      end
      for (int i = 0; i < 16; i++) r[127-8*i -: 8] = a[i];
      return r ^ k;
   endfunction

   function automatic logic [127:0] round_key(input logic [127:0] key, input int rnd);
      logic [31:0] w [44];
      logic [31:0] t;
      logic [7:0]  rc = 8'h01;
      for (int i = 0; i < 4; i++) w[i] = key[127-32*i -: 32];
      for (int i = 4; i < 44; i++) begin
         t = w[i-1];
         if (i % 4 == 0) begin
            t = {t[23:0], t[31:24]};
            t = {sbox[t[31:24]], sbox[t[23:16]], sbox[t[15:8]], sbox[t[7:0]]} ^ {rc, 24'h0};
            rc = xt(rc);
         end
         w[i] = w[i-4] ^ t;
      end
      return {w[4*rnd], w[4*rnd+1], w[4*rnd+2], w[4*rnd+3]};
   endfunction

   // Reference: whole-block AES-128 encryption.
   function automatic logic [127:0] aes_encrypt(input logic [127:0] pt, input logic [127:0] key);
      logic [127:0] s = pt ^ round_key(key, 0);
      for (int r = 1; r <= 10; r++) s = aes_round(s, round_key(key, r), r == 10);
      return s;
   endfunction

   // Toy 14-round cipher used with the NUM_ROUNDS=14 instance.
   function automatic logic [127:0] toy_key(input int r);
      logic [3:0] ri = 4'(r);
      return {8{ri, 4'h5, 8'h3c}};
   endfunction

   function automatic logic [127:0] toy14(input logic [127:0] pt);
      logic [127:0] s = pt ^ toy_key(0);
      for (int r = 1; r <= 14; r++)
         s = {s[126:0], s[127]} ^ toy_key(r) ^ ((r == 14) ? 128'hff : 128'h0);
      return s;
   endfunction

   // Environment: key schedule lookup and combinational round datapaths.
   assign rk_in        = rk_tab[rnd_idx];
   assign rnd_result   = aes_round(rnd_state, rk_in, rnd_last);
   assign rk_in_b      = {8{rnd_idx_b, 4'h5, 8'h3c}};
   assign rnd_result_b = {rnd_state_b[126:0], rnd_state_b[127]} ^ rk_in_b ^
                         (rnd_last_b ? 128'hff : 128'h0);

   // ---------------- helpers ----------------
   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %h want %h", nm, act, exp);
      end
   endtask

   task automatic set_key(input logic [127:0] key);
      for (int r = 0; r <= 10; r++) rk_tab[r] = round_key(key, r);
   endtask

   task automatic run_block(input logic [127:0] pt, input logic [127:0] key,
                            input logic [127:0] exp, input int hold, input bit toggle);
      set_key(key);
      in_block  = pt;
      in_valid  = 1'b1;
      out_ready = 1'b0;
      #1;
      chk("idle_in_ready", in_ready, 1);
      chk("idle_rnd_idx", rnd_idx, 0);
      step();
      for (int k = 1; k <= 10; k++) begin
         if (toggle) begin
            in_valid = 1'($urandom);
            in_block = {$urandom, $urandom, $urandom, $urandom};
         end else begin
            in_valid = 1'b0;
         end
         chk("rnd_idx_seq", rnd_idx, k);
         chk("rnd_last", rnd_last, (k == 10));
         chk("round_in_ready", in_ready, 0);
         chk("round_out_valid", out_valid, 0);
         chk("round_busy", busy, 1);
         step();
      end
      in_valid = 1'b0;
      chk("latency_out_valid", out_valid, 1);
      chk("ciphertext", out_block, exp);
      chk("done_rnd_idx", rnd_idx, DONE_IDX);
      for (int h = 0; h < hold; h++) begin
         step();
         chk("stall_out_valid", out_valid, 1);
         chk("stall_out_block", out_block, exp);
         chk("stall_rnd_idx", rnd_idx, DONE_IDX);
      end
      out_ready = 1'b1;
      step();
      out_ready = 1'b0;
      chk("after_xfer_out_valid", out_valid, 0);
      chk("after_xfer_busy", busy, 0);
      chk("after_xfer_in_ready", in_ready, 1);
      chk("after_xfer_rnd_idx", rnd_idx, 0);
   endtask

   typedef struct {
      logic [127:0] pt;
      logic [127:0] key;
      logic [127:0] ct;
      int           hold;
   } vec_t;

   initial begin
      vec_t         vt [4];
      logic [127:0] pt, key;
      logic [7:0]   inv;
      int           n, t1, t2;

      vt[0] = '{128'h00112233445566778899aabbccddeeff, 128'h000102030405060708090a0b0c0d0e0f,
                128'h69c4e0d86a7b0430d8cdb78070b4c55a, 0};
      vt[1] = '{128'h00112233445566778899aabbccddeeff, 128'h000102030405060708090a0b0c0d0e0f,
                128'h69c4e0d86a7b0430d8cdb78070b4c55a, 5};
      vt[2] = '{128'h3243f6a8885a308d313198a2e0370734, 128'h2b7e151628aed2a6abf7158809cf4f3c,
                128'h3925841d02dc09fbdc118597196a0b32, 2};
      vt[3] = '{128'h0, 128'h0, 128'h66e94bd4ef8a2c3b884cfa59ca342b2e, 1};

      // S-box from GF(2^8) inverse plus affine map.
      for (int x = 0; x < 256; x++) begin
         inv = 8'h00;
         for (int y = 1; y < 256; y++)
            if (gmul(8'(x), 8'(y)) == 8'h01) inv = 8'(y);
         sbox[x] = inv ^ rotl8(inv, 1) ^ rotl8(inv, 2) ^ rotl8(inv, 3) ^ rotl8(inv, 4) ^ 8'h63;
      end
      for (int r = 0; r < 16; r++) rk_tab[r] = '0;

      rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b0; in_block = '0;
      in_valid_b = 1'b0; out_ready_b = 1'b0; in_block_b = '0;
      step();
      step();
      chk("rst_in_ready", in_ready, 1);
      chk("rst_out_valid", out_valid, 0);
      chk("rst_busy", busy, 0);
      chk("rst_rnd_idx", rnd_idx, 0);
      chk("rst_rnd_last", rnd_last, 0);
      chk("rst_state", out_block, 0);
      rst_n = 1'b1;
      step();

      // Table-driven known-answer vectors.
      for (int i = 0; i < 4; i++) run_block(vt[i].pt, vt[i].key, vt[i].ct, vt[i].hold, 1'b0);

      // Reset in the middle of round 5.
      set_key(vt[0].key);
      in_block = vt[0].pt;
      in_valid = 1'b1;
      step();
      in_valid = 1'b0;
      n = 0;
      while (rnd_idx !== 4'd5 && n < 20) begin
         step();
         n++;
      end
      chk("reach_round5", rnd_idx, 5);
      rst_n = 1'b0;
      step();
      chk("midrst_rnd_idx", rnd_idx, 0);
      chk("midrst_state", rnd_state, 0);
      chk("midrst_out_valid", out_valid, 0);
      chk("midrst_busy", busy, 0);
      chk("midrst_rnd_last", rnd_last, 0);
      chk("midrst_in_ready", in_ready, 1);
      rst_n = 1'b1;
      for (int c = 0; c < 14; c++) begin
         step();
         chk("no_out_valid_after_rst", out_valid, 0);
      end
      run_block(vt[0].pt, vt[0].key, vt[0].ct, 0, 1'b0);

      // Reset while holding a result in DONE.
      set_key(vt[2].key);
      in_block = vt[2].pt;
      in_valid = 1'b1;
      step();
      in_valid = 1'b0;
      n = 0;
      while (out_valid !== 1'b1 && n < 20) begin
         step();
         n++;
      end
      chk("reach_done", out_valid, 1);
      rst_n = 1'b0;
      step();
      chk("donerst_out_valid", out_valid, 0);
      chk("donerst_busy", busy, 0);
      chk("donerst_rnd_idx", rnd_idx, 0);
      rst_n = 1'b1;
      step();

      // Back-to-back: in_valid held high, out_ready held high.
      set_key(vt[0].key);
      in_block  = vt[0].pt;
      out_ready = 1'b1;
      in_valid  = 1'b1;
      t1 = -1;
      t2 = -1;
      for (int c = 0; c < 60 && t2 < 0; c++) begin
         step();
         if (out_valid === 1'b1) begin
            chk("b2b_out_block", out_block, vt[0].ct);
            if (t1 < 0) t1 = c;
            else begin
               t2 = c;
               in_valid = 1'b0;
            end
         end
      end
      chk("b2b_first_latency", t1, 10);
      chk("b2b_gap", t2 - t1, EXP_GAP);
      step();
      out_ready = 1'b0;
      chk("b2b_idle_busy", busy, 0);
      chk("b2b_idle_in_ready", in_ready, 1);

      // Randomised blocks with random stalls and in_valid noise during rounds.
      for (int i = 0; i < 16; i++) begin
         pt  = {$urandom, $urandom, $urandom, $urandom};
         key = {$urandom, $urandom, $urandom, $urandom};
         run_block(pt, key, aes_encrypt(pt, key), int'($urandom_range(0, 3)), 1'b1);
      end

      // 14-round instance: index walk to 14 and final-round flag.
      for (int j = 0; j < 2; j++) begin
         pt = {$urandom, $urandom, $urandom, $urandom};
         in_block_b = pt;
         in_valid_b = 1'b1;
         #1;
         chk("nr14_in_ready", in_ready_b, 1);
         step();
         in_valid_b = 1'b0;
         for (int k = 1; k <= 14; k++) begin
            chk("nr14_rnd_idx", rnd_idx_b, k);
            chk("nr14_rnd_last", rnd_last_b, (k == 14));
            chk("nr14_busy", busy_b, 1);
            step();
         end
         chk("nr14_out_valid", out_valid_b, 1);
         chk("nr14_out_block", out_block_b, toy14(pt));
         out_ready_b = 1'b1;
         step();
         out_ready_b = 1'b0;
         chk("nr14_after_out_valid", out_valid_b, 0);
         chk("nr14_after_rnd_idx", rnd_idx_b, 0);
      end

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
